// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// Shared definitions for the nibble-serial adder: FSM encodings and slice width.
package nibble_serial_adder_ctrl_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nibble_serial_adder_ctrl_cla.sv
// Combinational 4-bit carry-lookahead adder.
// The top-level controller reuses this slice once per nibble.
module adder4bitcla_beh
    import nibble_serial_adder_ctrl_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] sum,
    output logic               cout
);

    logic [SLICE_W-1:0] g;
    logic [SLICE_W-1:0] p;
    logic [SLICE_W-1:0] c;

    assign g = a & b;
    assign p = a ^ b;

    // Each carry is flattened into generate/propagate terms, so no carry ripples between bits.
    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);

    generate
        for (genvar gi = 0; gi < SLICE_W; gi++) begin : g_sum
            assign sum[gi] = p[gi] ^ c[gi];
        end
    endgenerate

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Nibble-serial add/subtract unit.
// A single 4-bit CLA slice handles one nibble per cycle, LSB first.
module nibble_serial_adder_ctrl
    import nibble_serial_adder_ctrl_pkg::*;
#(
    parameter  int NIBBLES = 4,
    localparam int W       = SLICE_W * NIBBLES
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         sub,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         ovf
);

    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    state_t             state_reg;
    state_t             state_next;
    logic               accept_next;
    logic               last_nibble;

    logic [W-1:0]       a_reg;
    logic [W-1:0]       b_reg;
    logic               carry_reg;
    logic [IDX_W-1:0]   idx_reg;
    logic [W-1:0]       sum_reg;
    logic               cout_reg;
    logic               ovf_reg;

    logic [SLICE_W-1:0] slice_a;
    logic [SLICE_W-1:0] slice_b;
    logic [SLICE_W-1:0] slice_sum;
    logic               slice_cout;

    assign last_nibble = (idx_reg == IDX_W'(NIBBLES - 1));
    assign slice_a     = a_reg[idx_reg * SLICE_W +: SLICE_W];
    assign slice_b     = b_reg[idx_reg * SLICE_W +: SLICE_W];

    adder4bitcla_beh u_slice (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry_reg),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        accept_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next  = RUN;
                    accept_next = 1'b1;
                end
            end
            RUN: begin
                if (last_nibble) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    state_next  = RUN;
                    accept_next = 1'b1;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Subtraction is A + ~B + 1, so the inversion and the forced carry are applied at latch time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg     <= '0;
            b_reg     <= '0;
            carry_reg <= 1'b0;
            idx_reg   <= '0;
            sum_reg   <= '0;
            cout_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
        end else if (accept_next) begin
            a_reg     <= a;
            b_reg     <= sub ? ~b : b;
            carry_reg <= sub ? 1'b1 : cin;
            idx_reg   <= '0;
        end else if (state_reg == RUN) begin
            sum_reg[idx_reg * SLICE_W +: SLICE_W] <= slice_sum;
            carry_reg <= slice_cout;
            if (last_nibble) begin
                idx_reg  <= '0;
                cout_reg <= slice_cout;
                ovf_reg  <= (a_reg[W-1] == b_reg[W-1]) && (slice_sum[SLICE_W-1] != a_reg[W-1]);
            end else begin
                idx_reg <= idx_reg + IDX_W'(1);
            end
        end
    end

    assign busy = (state_reg == RUN);
    assign done = (state_reg == DONE);
    assign sum  = sum_reg;
    assign cout = cout_reg;
    assign ovf  = ovf_reg;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Directed bench for nibble_serial_adder_ctrl (NIBBLES=4).
// Expected results are queued at issue and compared when done pulses.
module tb_nibble_serial_adder_ctrl;

    localparam int NIB = 4;
    localparam int W   = 4 * NIB;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int   vectors     = 0;
    int   miscompares = 0;
    exp_t sb[$];

    nibble_serial_adder_ctrl #(.NIBBLES(NIB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: wide unsigned sum for sum/cout, signed integer range test for overflow.
    function automatic exp_t model(input logic s, input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic ci);
        exp_t         m;
        logic [W:0]   full;
        int           r;
        if (s) begin
            full = {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
            r    = int'($signed(x)) - int'($signed(y));
        end else begin
            full = {1'b0, x} + {1'b0, y} + (W+1)'(ci);
            r    = int'($signed(x)) + int'($signed(y)) + int'(ci);
        end
        m.sum  = full[W-1:0];
        m.cout = full[W];
        m.ovf  = (r > 32767) || (r < -32768);
        return m;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic start_op(input logic s, input logic [W-1:0] x, input logic [W-1:0] y,
                            input logic ci);
        sub   = s;
        a     = x;
        b     = y;
        cin   = ci;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (done) break;
        end
    endtask

    task automatic check_result(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check({tag, "_sum"}, 32'(sum), 32'(e.sum));
            check({tag, "_cout"}, 32'(cout), 32'(e.cout));
            check({tag, "_ovf"}, 32'(ovf), 32'(e.ovf));
            $display("op %s: sum=%h cout=%0b ovf=%0b (exp %h %0b %0b)",
                     tag, sum, cout, ovf, e.sum, e.cout, e.ovf);
        end
    endtask

    task automatic run_op(input string tag, input logic s, input logic [W-1:0] x,
                          input logic [W-1:0] y, input logic ci);
        int cyc;
        sb.push_back(model(s, x, y, ci));
        start_op(s, x, y, ci);
        check({tag, "_busy"}, 32'(busy), 32'd1);
        wait_done(cyc);
        check({tag, "_latency"}, 32'(cyc), 32'(NIB));
        check_result(tag);
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    task automatic count_dones(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (done) cnt++;
        end
    endtask

    initial begin
        int cyc;
        int nd;
        rst_n = 1'b1;
        start = 1'b0;
        sub   = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum",  32'(sum),  32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_ovf",  32'(ovf),  32'd0);

        // Start is presented on the very first edge after reset release.
        rst_n = 1'b1;
        run_op("add_1234", 1'b0, 16'h1234, 16'h0FFF, 1'b0);
        run_op("add_wrap", 1'b0, 16'hFFFF, 16'h0001, 1'b0);
        run_op("add_ovf",  1'b0, 16'h7FFF, 16'h0001, 1'b0);
        run_op("sub_neg",  1'b1, 16'h0005, 16'h0007, 1'b1);
        run_op("sub_ovf",  1'b1, 16'h8000, 16'h0001, 1'b0);
        run_op("add_cin",  1'b0, 16'h00FF, 16'h0F00, 1'b1);
        for (int i = 0; i < 4; i++) begin
            run_op($sformatf("rand%0d", i), 1'($urandom_range(0, 1)), 16'($urandom),
                   16'($urandom), 1'($urandom_range(0, 1)));
        end

        // Start pulsed during RUN must be ignored.
        sb.push_back(model(1'b0, 16'h1111, 16'h2222, 1'b0));
        start_op(1'b0, 16'h1111, 16'h2222, 1'b0);
        @(posedge clk);
        #1;
        start_op(1'b0, 16'hAAAA, 16'h5555, 1'b0);
        wait_done(cyc);
        check("ign_latency", 32'(cyc), 32'(NIB - 2));
        check_result("ign");
        count_dones(8, nd);
        check("ign_extra_done", 32'(nd), 32'd0);

        // Start held in DONE: second op begins without an idle cycle.
        sb.push_back(model(1'b0, 16'h0F0F, 16'h0101, 1'b0));
        start_op(1'b0, 16'h0F0F, 16'h0101, 1'b0);
        wait_done(cyc);
        check("b2b1_latency", 32'(cyc), 32'(NIB));
        check_result("b2b1");
        sb.push_back(model(1'b1, 16'h0100, 16'h0200, 1'b0));
        start_op(1'b1, 16'h0100, 16'h0200, 1'b0);
        check("b2b2_busy", 32'(busy), 32'd1);
        wait_done(cyc);
        check("b2b2_latency", 32'(cyc), 32'(NIB));
        check_result("b2b2");

        // Reset in the second RUN cycle aborts the operation.
        run_op("pre_rst", 1'b0, 16'hFFFF, 16'hFFFF, 1'b1);
        start_op(1'b0, 16'h1234, 16'h4321, 1'b0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_sum",  32'(sum),  32'd0);
        check("abort_cout", 32'(cout), 32'd0);
        check("abort_ovf",  32'(ovf),  32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        count_dones(8, nd);
        check("abort_no_done", 32'(nd), 32'd0);
        run_op("post_rst", 1'b0, 16'h4321, 16'h1234, 1'b0);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/nibble_serial_adder_ctrl.md
NIBBLE_SERIAL_ADDER_CTRL -- requirements
Module: nibble_serial_adder_ctrl

Interface
REQ-001 SHALL have parameter NIBBLES, default 4, the number of 4-bit slices per operand; W = 4*NIBBLES.
REQ-002 SHALL have one clock and an asynchronous, active-low reset.
REQ-003 Port: clk  input  1  rising-edge clock for all state.
REQ-004 Port: rst_n  input  1  asynchronous active-low reset.
REQ-005 Port: start  input  1  request pulse; sampled on a rising clk edge.
REQ-006 Port: sub  input  1  operation select, sampled with start: 0 = A+B+cin, 1 = A-B.
REQ-007 Port: a  input  W  operand A, sampled with start.
REQ-008 Port: b  input  W  operand B, sampled with start.
REQ-009 Port: cin  input  1  carry-in, sampled with start; ignored when sub=1.
REQ-010 Port: busy  output  1  high while nibbles are being processed.
REQ-011 Port: done  output  1  one-cycle pulse when the result is valid.
REQ-012 Port: sum  output  W  result word.
REQ-013 Port: cout  output  1  carry out of bit W-1; for subtract, 1 = no borrow.
REQ-014 Port: ovf  output  1  two's-complement signed overflow.

Function
REQ-015 SHALL compute the W-bit result with one 4-bit carry-lookahead slice, reused over NIBBLES cycles, LSB nibble first.
REQ-016 The FSM SHALL have states IDLE, RUN and DONE; the reset state is IDLE.
REQ-017 In IDLE or DONE, when start=1 at a rising edge:
- latch a as the A operand;
- latch b as B, or as ~b when sub=1;
- set the carry register to cin, or to 1 when sub=1;
- set the nibble index to 0;
- go to RUN.
REQ-018 In RUN, each edge SHALL:
- add A and B nibble[idx] plus the carry register;
- write the 4-bit result into sum nibble[idx];
- load the slice carry-out into the carry register;
- increment idx.
REQ-019 After the edge that processes nibble NIBBLES-1, the FSM SHALL enter DONE.
REQ-020 In DONE, the FSM SHALL go to IDLE on the next edge unless start=1.
REQ-021 Latency: if start is sampled at edge k, done SHALL be high during the cycle after edge k+NIBBLES, for exactly one cycle.
REQ-022 busy SHALL be 1 exactly when state = RUN.
REQ-023 done SHALL be 1 exactly when state = DONE.
REQ-024 start while in RUN SHALL be ignored; there is no queueing and latched operands stay unchanged.
REQ-025 start in DONE SHALL be accepted, giving back-to-back operations with no idle cycle.
REQ-026 cout SHALL equal the final carry register.
REQ-027 ovf SHALL be (A[W-1] == B'[W-1]) && (sum[W-1] != A[W-1]), where B' is the latched, possibly inverted, B.
- cout and ovf SHALL update at the edge that enters DONE.
REQ-028 sum, cout and ovf SHALL hold their values from that edge until the next operation's first RUN edge.
- Partial sum nibbles are visible while busy=1.
REQ-029 idx SHALL wrap to 0 on every new start.
- Values of idx at or beyond NIBBLES are unreachable.

Reset
REQ-030 When rst_n=0, the block SHALL asynchronously force:
- state = IDLE, idx = 0, carry register = 0;
- busy = 0, done = 0;
- sum = 0, cout = 0, ovf = 0.
REQ-031 Assertion of rst_n=0 in the middle of RUN SHALL abort the operation and produce no done pulse.
REQ-032 The first start SHALL be accepted on the first rising edge with rst_n=1.

Structure
REQ-033 A shared package/header SHALL hold:
- the state encodings IDLE=2'd0, RUN=2'd1, DONE=2'd2;
- the slice width constant 4.
REQ-034 The block SHALL instantiate exactly one adder4bitcla_beh as its arithmetic slice.
- No other adder logic is permitted in the datapath.
REQ-035 Nibble selection SHALL be an idx-indexed part-select; idx width = clog2(NIBBLES), minimum 1.

Verification (NIBBLES=4)
REQ-036 a=0x1234, b=0x0FFF, cin=0, sub=0 -> sum=0x2233, cout=0, ovf=0; done exactly 4 cycles after the start edge.
REQ-037 a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0.
- a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, ovf=1.
REQ-038 sub=1: a=0x0005, b=0x0007, cin=1 -> sum=0xFFFE, cout=0, ovf=0 (cin ignored).
- sub=1: a=0x8000, b=0x0001 -> sum=0x7FFF, ovf=1.
REQ-039 Start 0x1111+0x2222, then pulse start with 0xAAAA+0x5555 two cycles later (during RUN) -> single done, sum=0x3333.
- A start held high in DONE -> second result one NIBBLES+1 period later with no idle gap.
REQ-040 Drop rst_n low in the 2nd RUN cycle -> busy=0, done=0, sum=0 immediately.
- No done pulse follows.
- The next start completes normally.
